// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, forwarding and data-memory wait controller
//
// Purpose:
//   Drives the Stall*/Flush* controls of the 5-stage RV32 pipeline, the EX-stage
//   forwarding selects, and a req/ack handshake to a variable-latency data memory.
//   Stall*=1 holds a pipeline register, Flush*=1 loads a bubble into it.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   Rs1D, Rs2D                 source registers in Decode
//   Rs1E, Rs2E                 source registers in Execute
//   RdE, RdM, RdW              destination registers in Execute/Memory/Writeback
//   RegWriteM, RegWriteW       register write enables in Memory/Writeback
//   ResultSrcE                 2'b01 marks a load in Execute
//   PCSrcE                     taken branch / jal / jalr in Execute
//   MemAccessM                 load or store in Memory
//   DMemAck                    data memory completed the access this cycle
//   DMemReq                    access request to data memory
//   StallF/D/E/M               hold PC / FD / DE / EM register
//   FlushD/E/W                 bubble into FD / DE / MW register
//   ForwardAE/BE               00 register file, 10 ALUResultM, 01 ResultW
//   MemErr                     sticky memory-timeout flag

module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemAccessM,
  input  logic              DMemAck,
  output logic              DMemReq,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err;

  logic             freeze;
  logic             lw_stall;
  logic             req_raw;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // Memory wait FSM. The counter counts WAIT cycles without an ack; the
  // last allowed one (TIMEOUT-1) without an ack drops into ERR for good.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MemAccessM && !DMemAck) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (DMemAck) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state   <= S_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Freeze and request decode. On the ack cycle the freeze drops so the
  // instruction in M advances in the same cycle its data arrives.
  always_comb begin
    freeze  = 1'b0;
    req_raw = 1'b0;
    case (state)
      S_IDLE: begin
        req_raw = MemAccessM;
        freeze  = MemAccessM & ~DMemAck;
      end
      S_WAIT: begin
        req_raw = 1'b1;
        freeze  = ~DMemAck;
      end
      S_ERR: begin
        req_raw = 1'b0;
        freeze  = 1'b1;
      end
      default: begin
        req_raw = 1'b0;
        freeze  = 1'b0;
      end
    endcase
  end

  // Forwarding select for one EX operand; the younger producer in M wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    fwd_b = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Output resolution. Reset forces the bubble pattern even though most
  // outputs are combinational, so nothing escapes while the core is held.
  // During a freeze E is held, so a branch or load-use in E simply waits
  // and is resolved on the release cycle.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    DMemReq   = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      DMemReq   = req_raw;
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        // The squashed D instruction is also the load's would-be consumer.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign MemErr = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl

module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;
  localparam int TO     = 200;

  logic              clk;
  logic              reset;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MemAccessM, DMemAck;
  logic              DMemReq, StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW, MemErr;
  logic [1:0]        ForwardAE, ForwardBE;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .DMemAck(DMemAck), .DMemReq(DMemReq),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, DMemReq, MemErr}
  logic [12:0] obs;
  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, DMemReq, MemErr};

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;

  localparam logic [3:0] ST_NONE = 4'b0000;
  localparam logic [3:0] ST_ALL  = 4'b1111;
  localparam logic [3:0] ST_LW   = 4'b1100;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_RST  = 3'b111;
  localparam logic [2:0] FL_FRZ  = 3'b001;
  localparam logic [2:0] FL_BR   = 3'b110;
  localparam logic [2:0] FL_LW   = 3'b010;

  function automatic logic [12:0] mk(input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic req, input logic err);
    return {st, fl, fa, fb, req, err};
  endfunction

  task automatic push(input string tag, input logic [12:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%b required=entry", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) passed++;
      else $error("FAIL %s observed=%b required=%b", e.tag, obs, e.v);
    end
  endtask

  // One cycle: expectation queued as inputs settle, checked on the falling edge.
  task automatic step(input string tag, input logic [12:0] v);
    push(tag, v);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0;
    MemAccessM = 1'b0; DMemAck = 1'b0;
  endtask

  initial begin
    // Reset overrides every hazard source.
    reset = 1'b0;
    clr();
    MemAccessM = 1'b1; RegWriteM = 1'b1; RdM = 5; Rs1E = 5;
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 1'b1;
    step("reset", mk(ST_NONE, FL_RST, 2'b00, 2'b00, 1'b0, 1'b0));
    reset = 1'b1;
    clr();
    step("idle", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // Forwarding.
    RegWriteM = 1'b1; RdM = 5; Rs1E = 5; RegWriteW = 1'b1; RdW = 6; Rs2E = 6;
    step("fwd_m_w", mk(ST_NONE, FL_NONE, 2'b10, 2'b01, 1'b0, 1'b0));
    RdW = 5;
    step("fwd_m_prio", mk(ST_NONE, FL_NONE, 2'b10, 2'b00, 1'b0, 1'b0));
    RegWriteM = 1'b0;
    step("fwd_w_only", mk(ST_NONE, FL_NONE, 2'b01, 2'b00, 1'b0, 1'b0));
    RegWriteM = 1'b1; RdM = 0; Rs1E = 0; RdW = 6; Rs2E = 6;
    step("fwd_x0", mk(ST_NONE, FL_NONE, 2'b00, 2'b01, 1'b0, 1'b0));
    RdM = 5; Rs2E = 5; RdW = 5;
    step("fwd_b_m", mk(ST_NONE, FL_NONE, 2'b00, 2'b10, 1'b0, 1'b0));

    // Load-use.
    clr(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; Rs2D = 1;
    step("lw_stall", mk(ST_LW, FL_LW, 2'b00, 2'b00, 1'b0, 1'b0));
    clr(); Rs1E = 7; Rs2E = 1; RdM = 7; RegWriteM = 1'b1;
    step("lw_fwd_m", mk(ST_NONE, FL_NONE, 2'b10, 2'b00, 1'b0, 1'b0));
    clr(); Rs1E = 7; RdW = 7; RegWriteW = 1'b1;
    step("lw_fwd_w", mk(ST_NONE, FL_NONE, 2'b01, 2'b00, 1'b0, 1'b0));
    clr(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    step("lw_x0", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    clr(); ResultSrcE = 2'b10; RdE = 7; Rs2D = 7;
    step("non_load", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    ResultSrcE = 2'b01;
    step("lw_rs2", mk(ST_LW, FL_LW, 2'b00, 2'b00, 1'b0, 1'b0));

    // Branch beats load-use.
    PCSrcE = 1'b1;
    step("br_over_lw", mk(ST_NONE, FL_BR, 2'b00, 2'b00, 1'b0, 1'b0));
    clr();
    step("br_after", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // Store with ack on the fourth request cycle; hazards deferred meanwhile.
    MemAccessM = 1'b1;
    step("mem_c0", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b1, 1'b0));
    PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    step("mem_c1_defer", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b1, 1'b0));
    PCSrcE = 1'b0; RegWriteM = 1'b1; RdM = 5; Rs1E = 5;
    step("mem_c2_fwd", mk(ST_ALL, FL_FRZ, 2'b10, 2'b00, 1'b1, 1'b0));
    DMemAck = 1'b1;
    step("mem_ack_lw", mk(ST_LW, FL_LW, 2'b10, 2'b00, 1'b1, 1'b0));
    clr();
    step("mem_idle", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // Zero-wait access and stray ack.
    MemAccessM = 1'b1; DMemAck = 1'b1;
    step("zero_wait", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b1, 1'b0));
    MemAccessM = 1'b0;
    step("ack_ignored", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    clr();
    step("still_idle", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // Reset mid-WAIT drops the request without waiting for a clock edge.
    MemAccessM = 1'b1;
    step("w_c0", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b1, 1'b0));
    step("w_c1", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b1, 1'b0));
    reset = 1'b0;
    push("rst_midwait", mk(ST_NONE, FL_RST, 2'b00, 2'b00, 1'b0, 1'b0));
    #1;
    compare();
    tick();
    reset = 1'b1; MemAccessM = 1'b0;
    step("rst_idle", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // Timeout: one IDLE request cycle then TO WAIT cycles, then ERR.
    MemAccessM = 1'b1;
    step("to_c0", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b1, 1'b0));
    for (int i = 1; i < TO; i++) tick();
    step("to_last_wait", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b1, 1'b0));
    step("to_err", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b0, 1'b1));
    DMemAck = 1'b1;
    step("err_ack", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b0, 1'b1));
    clr();
    step("err_hold", mk(ST_ALL, FL_FRZ, 2'b00, 2'b00, 1'b0, 1'b1));
    reset = 1'b0;
    step("err_reset", mk(ST_NONE, FL_RST, 2'b00, 2'b00, 1'b0, 1'b0));
    reset = 1'b1;
    step("final_idle", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
